// File: rtl/write_packer_pkg.sv
// Shared definitions for the write-side packer and the matching read-side unpacker.
// Holds the pack state encoding and the fill-counter width helper.
package write_packer_pkg;

  typedef enum logic [1:0] {
    EMPTY   = 2'd0,
    FILLING = 2'd1,
    PACKED  = 2'd2
  } pack_state_e;

  // Counter wide enough to hold 0..pw inclusive.
  function automatic int cnt_w(input int pw);
    return $clog2(pw + 1);
  endfunction

endpackage

// File: rtl/write_packer.sv
// Packs PW single words from a valid/ready source into one parallel write for
// CircularBuffer; a flush pads out and emits a partially filled pack.
module write_packer
  import write_packer_pkg::*;
#(
  parameter int               WIDTH = 16,
  parameter int               PW    = 4,
  parameter logic [WIDTH-1:0] PAD   = '0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   s_valid,
  input  logic [WIDTH-1:0]       s_data,
  output logic                   s_ready,
  input  logic                   flush,
  input  logic                   buf_ready,
  output logic                   wEn,
  output logic [PW*WIDTH-1:0]    out,
  output logic [cnt_w(PW)-1:0]   fill
);

  localparam int               CNT_W = cnt_w(PW);
  localparam logic [CNT_W-1:0] FULL  = CNT_W'(PW);

  pack_state_e              state, state_nxt;
  logic [CNT_W-1:0]         fill_nxt, fill_acc;
  logic [PW-1:0][WIDTH-1:0] pack;
  logic [PW-1:0]            slot_wr, slot_pad;
  logic                     accept, do_flush;

  assign s_ready  = rst && (state != PACKED);
  assign accept   = s_valid && s_ready;
  assign wEn      = (state == PACKED) && buf_ready;
  assign fill_acc = fill + CNT_W'(accept);
  // Flush counts the word accepted this cycle; nothing held means nothing to emit.
  assign do_flush = flush && (state != PACKED) && (fill_acc != '0);
  assign out      = pack;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= EMPTY;
      fill  <= '0;
    end else begin
      state <= state_nxt;
      fill  <= fill_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    fill_nxt  = fill;
    if (wEn) begin
      state_nxt = EMPTY;
      fill_nxt  = '0;
    end else if (do_flush) begin
      state_nxt = PACKED;
      fill_nxt  = FULL;
    end else if (accept) begin
      fill_nxt  = fill_acc;
      state_nxt = (fill_acc == FULL) ? PACKED : FILLING;
    end
  end

  // Incoming word goes to slot 'fill'; padding covers slots above the post-accept fill.
  for (genvar k = 0; k < PW; k++) begin : g_slot
    assign slot_wr[k]  = accept && (fill == CNT_W'(k));
    assign slot_pad[k] = do_flush && (CNT_W'(k) >= fill_acc);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pack <= '0;
    end else if (wEn) begin
      pack <= '0;
    end else begin
      for (int k = 0; k < PW; k++) begin
        if (slot_wr[k])       pack[k] <= s_data;
        else if (slot_pad[k]) pack[k] <= PAD;
      end
    end
  end

  a_fill_range: assert property (@(posedge clk) disable iff (!rst) fill <= FULL);

endmodule

// File: tb/tb_write_packer.sv
// Directed bench for write_packer (WIDTH=16, PW=4, PAD=16'hFFFF) with
// hand-computed expected packs and a per-cycle wEn monitor.
module tb_write_packer;

  localparam int WIDTH = 16;
  localparam int PW    = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              s_valid;
  logic [WIDTH-1:0]  s_data;
  logic              s_ready;
  logic              flush;
  logic              buf_ready;
  logic              wEn;
  logic [PW*WIDTH-1:0] out;
  logic [2:0]        fill;

  int checks = 0;
  int errors = 0;
  int wen_seen = 0;
  localparam int EXP_PACKS = 5;

  write_packer #(.WIDTH(WIDTH), .PW(PW), .PAD(16'hFFFF)) dut (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
    .flush(flush), .buf_ready(buf_ready), .wEn(wEn), .out(out), .fill(fill)
  );

  always #5 clk = ~clk;

  // wEn may only appear with a complete pack held
  always @(negedge clk) begin
    if (rst && wEn) begin
      wen_seen++;
      checks++;
      if (fill !== 3'd4) begin
        errors++;
        $display("FAIL wen_when_packed: fill=%0d required 4", fill);
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic send(input logic [WIDTH-1:0] d, input int exp_fill);
    s_valid = 1'b1; s_data = d;
    tick();
    s_valid = 1'b0;
    checks++;
    if (fill !== 3'(exp_fill)) begin
      errors++;
      $display("FAIL send_fill: data=%0d fill=%0d required %0d", d, fill, exp_fill);
    end
  endtask

  task automatic check_write(input string name, input logic [PW*WIDTH-1:0] exp);
    checks++;
    if (wEn !== 1'b1 || out !== exp) begin
      errors++;
      $display("FAIL %s: wEn=%0b out=%h required wEn=1 out=%h", name, wEn, out, exp);
    end
    tick();
    checks++;
    if (wEn !== 1'b0 || fill !== 3'd0 || s_ready !== 1'b1 || out !== '0) begin
      errors++;
      $display("FAIL %s_after: wEn=%0b fill=%0d s_ready=%0b out=%h required 0,0,1,0",
               name, wEn, fill, s_ready, out);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0; s_valid = 1'b1; s_data = 16'd99; flush = 1'b0; buf_ready = 1'b1;
    repeat (3) tick();
    checks++;
    if (s_ready !== 1'b0 || wEn !== 1'b0 || fill !== 3'd0 || out !== '0) begin
      errors++;
      $display("FAIL reset_hold: s_ready=%0b wEn=%0b fill=%0d out=%h required all 0",
               s_ready, wEn, fill, out);
    end
    s_valid = 1'b0;
    rst = 1'b1;
    tick();
    checks++;
    if (s_ready !== 1'b1 || fill !== 3'd0) begin
      errors++;
      $display("FAIL reset_release: s_ready=%0b fill=%0d required 1,0", s_ready, fill);
    end
  endtask

  task automatic test_back_to_back();
    buf_ready = 1'b1;
    send(16'd5, 1); send(16'd1, 2); send(16'd8, 3); send(16'd12, 4);
    checks++;
    if (s_ready !== 1'b0) begin
      errors++;
      $display("FAIL b2b_ready: s_ready=%0b required 0", s_ready);
    end
    check_write("b2b_write", {16'd12, 16'd8, 16'd1, 16'd5});
  endtask

  task automatic test_backpressure();
    buf_ready = 1'b0;
    send(16'd170, 1); send(16'd150, 2); send(16'd130, 3); send(16'd120, 4);
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (wEn !== 1'b0 || s_ready !== 1'b0 || out !== {16'd120, 16'd130, 16'd150, 16'd170}) begin
        errors++;
        $display("FAIL bp_hold: cyc=%0d wEn=%0b s_ready=%0b out=%h", i, wEn, s_ready, out);
      end
      tick();
    end
    buf_ready = 1'b1;
    #1;
    check_write("bp_write", {16'd120, 16'd130, 16'd150, 16'd170});
  endtask

  task automatic test_flush();
    send(16'd7, 1); send(16'd9, 2);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check_write("flush_write", {16'hFFFF, 16'hFFFF, 16'd9, 16'd7});
    flush = 1'b1;
    tick();
    flush = 1'b0;
    for (int i = 0; i < 10; i++) begin
      checks++;
      if (wEn !== 1'b0 || fill !== 3'd0) begin
        errors++;
        $display("FAIL flush_empty: cyc=%0d wEn=%0b fill=%0d required 0,0", i, wEn, fill);
      end
      tick();
    end
  endtask

  task automatic test_flush_coincident();
    send(16'd3, 1); send(16'd4, 2); send(16'd5, 3);
    s_valid = 1'b1; s_data = 16'd6; flush = 1'b1;
    tick();
    s_valid = 1'b0; flush = 1'b0;
    checks++;
    if (fill !== 3'd4) begin
      errors++;
      $display("FAIL coinc_fill: fill=%0d required 4", fill);
    end
    check_write("coinc_write", {16'd6, 16'd5, 16'd4, 16'd3});
  endtask

  task automatic test_reset_mid();
    send(16'd1, 1); send(16'd2, 2); send(16'd3, 3);
    #2 rst = 1'b0;
    #1;
    checks++;
    if (fill !== 3'd0 || wEn !== 1'b0 || s_ready !== 1'b0 || out !== '0) begin
      errors++;
      $display("FAIL reset_mid: fill=%0d wEn=%0b s_ready=%0b out=%h required 0,0,0,0",
               fill, wEn, s_ready, out);
    end
    tick();
    rst = 1'b1;
    tick();
    send(16'd10, 1); send(16'd20, 2); send(16'd30, 3); send(16'd40, 4);
    check_write("reset_mid_write", {16'd40, 16'd30, 16'd20, 16'd10});
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_backpressure();
    test_flush();
    test_flush_coincident();
    test_reset_mid();
    repeat (2) tick();
    checks++;
    if (wen_seen !== EXP_PACKS) begin
      errors++;
      $display("FAIL wen_count: wEn pulses=%0d required %0d", wen_seen, EXP_PACKS);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
